// File: rtl/gpr_ctx_engine.sv
// Context save/restore engine for the general-purpose register file.
// Define GPR_CTX_CSUM_EN to enable the XOR context checksum on ctx_csum.
module gpr_ctx_engine #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              save_start,
  input  logic              restore_start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_dest,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] ctx_csum
);

  // state   | meaning
  // IDLE    | waiting for save_start / restore_start
  // SAVE    | streaming R[0..NUM_REGS-1] out, rf_read_addr = next word to load
  // RESTORE | accepting words, each handshake becomes a write one cycle later
  // FINISH  | drain pending write, then pulse done and return to IDLE
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] SECOND = (NUM_REGS > 1) ? ADDR_W'(1) : '0;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              out_hs;
  logic              in_hs;
  logic              start_take;

  assign out_hs = out_valid & out_ready;
  assign in_hs  = in_valid & in_ready;
  // The done cycle is still treated as part of the finished operation.
  assign start_take = (state == IDLE) && !done && (save_start || restore_start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rf_read_addr  <= '0;
      rf_write_en   <= 1'b0;
      rf_write_dest <= '0;
      rf_write_data <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_addr      <= '0;
      in_ready      <= 1'b0;
    end else begin
      rf_write_en <= 1'b0;
      done        <= 1'b0;
      if (abort && state != IDLE) begin
        state        <= IDLE;
        idx          <= '0;
        busy         <= 1'b0;
        out_valid    <= 1'b0;
        in_ready     <= 1'b0;
        rf_read_addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_take) begin
              idx  <= '0;
              busy <= 1'b1;
              if (save_start) begin
                // rf_read_addr sits at 0 in IDLE, so R[0] is already on the read port.
                state        <= SAVE;
                out_valid    <= 1'b1;
                out_data     <= rf_read_data;
                out_addr     <= '0;
                rf_read_addr <= SECOND;
              end else begin
                state    <= RESTORE;
                in_ready <= 1'b1;
              end
            end
          end
          SAVE: begin
            if (out_hs) begin
              if (out_addr == LAST) begin
                state        <= FINISH;
                out_valid    <= 1'b0;
                rf_read_addr <= '0;
              end else begin
                out_data     <= rf_read_data;
                out_addr     <= out_addr + ADDR_W'(1);
                idx          <= out_addr + ADDR_W'(1);
                rf_read_addr <= (rf_read_addr == LAST) ? LAST : rf_read_addr + ADDR_W'(1);
              end
            end
          end
          RESTORE: begin
            if (in_hs) begin
              rf_write_en   <= 1'b1;
              rf_write_dest <= idx;
              rf_write_data <= in_data;
              if (idx == LAST) begin
                state    <= FINISH;
                in_ready <= 1'b0;
                idx      <= '0;
              end else begin
                idx <= idx + ADDR_W'(1);
              end
            end
          end
          FINISH: begin
            if (!rf_write_en) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              idx   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef GPR_CTX_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (start_take) begin
      csum_q <= '0;
    end else if (out_hs && !abort) begin
      csum_q <= csum_q ^ out_data;
    end else if (in_hs && !abort) begin
      csum_q <= csum_q ^ in_data;
    end
  end

  assign ctx_csum = csum_q;
`else
  assign ctx_csum = '0;
`endif

endmodule

// File: tb/tb_gpr_ctx_engine.sv
// Self-checking bench for gpr_ctx_engine: register file model plus a
// word-list reference model for save streams and restore writes.
module tb_gpr_ctx_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        save_start, restore_start, abort;
  logic        busy, done;
  logic [2:0]  rf_read_addr;
  logic [15:0] rf_read_data;
  logic        rf_write_en;
  logic [2:0]  rf_write_dest;
  logic [15:0] rf_write_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_addr;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic [15:0] ctx_csum;

  logic [15:0] rf [8];
  logic [15:0] vals [8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;

  gpr_ctx_engine dut (
    .clk(clk), .rst_n(rst_n), .save_start(save_start), .restore_start(restore_start),
    .abort(abort), .busy(busy), .done(done), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .rf_write_en(rf_write_en), .rf_write_dest(rf_write_dest),
    .rf_write_data(rf_write_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ctx_csum(ctx_csum)
  );

  always #5 clk = ~clk;

  assign rf_read_data = rf[rf_read_addr];

  always @(posedge clk) begin
    if (pre_en) begin
      rf[pre_addr] <= pre_data;
    end else if (rf_write_en) begin
      rf[rf_write_dest] <= rf_write_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] csum_exp(input logic [15:0] acc);
`ifdef GPR_CTX_CSUM_EN
    return acc;
`else
    return 16'h0000 & acc;
`endif
  endfunction

  task automatic preload_vals();
    for (int i = 0; i < 8; i++) begin
      pre_en = 1'b1; pre_addr = 3'(i); pre_data = vals[i];
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_save(input int mode, input bit both, input bit mid_restore);
    logic [15:0] exp_w [8];
    logic [15:0] held_d, acc;
    logic [2:0]  held_a;
    int k, wr0;
    bit stalled, got_done;
    exp_w = rf; wr0 = wr_count; acc = '0; k = 0; stalled = 0; got_done = 0;
    held_d = '0; held_a = '0;
    @(posedge clk); #1;
    save_start = 1'b1; restore_start = both;
    @(posedge clk); #1;
    save_start = 1'b0; restore_start = 1'b0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      restore_start = mid_restore && (cyc == 3);
      @(negedge clk);
      if (cyc == 0) chk("save_first_valid", out_valid, 1);
      if (stalled) begin
        chk("save_hold_data", out_data, held_d);
        chk("save_hold_addr", out_addr, held_a);
      end
      stalled = 0;
      if (done) begin
        got_done = 1;
        chk("save_beats", k, 8);
        chk("save_busy_at_done", busy, 0);
        chk("save_csum", ctx_csum, csum_exp(acc));
      end else if (out_valid && out_ready) begin
        chk("save_beat_in_range", k < 8, 1);
        if (k < 8) begin
          chk("save_data", out_data, exp_w[k]);
          chk("save_addr", out_addr, k);
          acc ^= exp_w[k];
        end
        k++;
      end else if (out_valid) begin
        stalled = 1; held_d = out_data; held_a = out_addr;
      end
      @(posedge clk); #1;
    end
    restore_start = 1'b0; out_ready = 1'b0;
    chk("save_done_seen", got_done, 1);
    @(negedge clk);
    chk("save_done_one_cycle", done, 0);
    chk("save_idle_busy", busy, 0);
    chk("save_no_writes", wr_count - wr0, 0);
    @(posedge clk); #1;
  endtask

  // mode 0: valid always, 1: random valid; abort_after >= 0 aborts after that many handshakes
  task automatic run_restore(input int mode, input int abort_after);
    logic [15:0] old [8];
    logic [15:0] exp_data, acc;
    logic [2:0]  exp_dest;
    int k, wr0, post;
    bit prev_hs, got_done, aborted;
    old = rf; wr0 = wr_count; acc = '0;
    k = 0; post = 0; prev_hs = 0; got_done = 0; aborted = 0;
    exp_data = '0; exp_dest = '0;
    @(posedge clk); #1;
    restore_start = 1'b1;
    @(posedge clk); #1;
    restore_start = 1'b0;
    for (int cyc = 0; cyc < 300 && !got_done && post < 4; cyc++) begin
      if (aborted) begin
        abort = 1'b0; in_valid = 1'b0; post++;
      end else begin
        in_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        in_data  = (k < 8) ? vals[k] : 16'($urandom);
        abort    = (abort_after >= 0) && (k == abort_after);
        if (abort) in_valid = 1'b1;
      end
      @(negedge clk);
      if (cyc == 0) chk("rst_first_ready", in_ready, 1);
      chk("rst_write_en", rf_write_en, prev_hs);
      if (prev_hs) begin
        chk("rst_write_dest", rf_write_dest, exp_dest);
        chk("rst_write_data", rf_write_data, exp_data);
      end
      if (aborted) begin
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_no_done", done, 0);
      end
      if (done) begin
        got_done = 1;
        chk("rst_words", k, 8);
        chk("rst_busy_at_done", busy, 0);
        chk("rst_csum", ctx_csum, csum_exp(acc));
      end
      prev_hs = in_valid && in_ready && !abort;
      if (prev_hs) begin
        exp_dest = 3'(k); exp_data = in_data; acc ^= in_data; k++;
      end
      if (abort) aborted = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; abort = 1'b0;
    if (abort_after < 0) begin
      chk("rst_done_seen", got_done, 1);
      chk("rst_write_count", wr_count - wr0, 8);
      for (int i = 0; i < 8; i++) chk("rst_readback", rf[i], vals[i]);
    end else begin
      chk("abort_done_absent", got_done, 0);
      chk("abort_write_count", wr_count - wr0, abort_after);
      for (int i = 0; i < 8; i++)
        chk("abort_readback", rf[i], (i < abort_after) ? vals[i] : old[i]);
    end
    @(negedge clk);
    chk("rst_idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; save_start = 1'b0; restore_start = 1'b0; abort = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_write_en", rf_write_en, 0);
    chk("reset_read_addr", rf_read_addr, 0);
    chk("reset_csum", ctx_csum, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) vals[i] = 16'h1110 + 16'(i);
    preload_vals();
    run_save(0, 0, 0);
    run_save(1, 0, 0);

    for (int i = 0; i < 8; i++) vals[i] = 16'hA000 + 16'(i);
    run_restore(0, -1);
    run_save(0, 1, 1);

    for (int i = 0; i < 8; i++) vals[i] = 16'h0001 << i;
    run_restore(0, -1);

    for (int i = 0; i < 8; i++) vals[i] = 16'($urandom);
    preload_vals();
    run_save(2, 0, 0);
    for (int i = 0; i < 8; i++) vals[i] = 16'($urandom);
    run_restore(1, -1);

    for (int i = 0; i < 8; i++) vals[i] = 16'($urandom);
    run_restore(0, 3);

    // reset while a save is stalled
    for (int i = 0; i < 8; i++) vals[i] = 16'h5A00 | 16'(i + 1);
    preload_vals();
    out_ready = 1'b0;
    @(posedge clk); #1; save_start = 1'b1;
    @(posedge clk); #1; save_start = 1'b0;
    @(posedge clk); #2;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_out_data", out_data, 0);
    chk("mid_reset_out_addr", out_addr, 0);
    chk("mid_reset_read_addr", rf_read_addr, 0);
    chk("mid_reset_in_ready", in_ready, 0);
    chk("mid_reset_csum", ctx_csum, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_ctx_engine.md
Name: gpr_ctx_engine

Overview:
Context save/restore initiator for the 8 x 16-bit general-purpose register file.
- On a save command it drives the file's read port, walks registers 0..NUM_REGS-1, and streams each word out over a valid/ready interface toward memory.
- On a restore command it accepts NUM_REGS words over a valid/ready input and drives the file's write port.
- It sits beside the core's datapath and is used for interrupt entry/exit and task switch. The core is stalled while busy=1.

Parameters:
DATA_W, 16, register word width.
ADDR_W, 3, register address width.
NUM_REGS, 8, registers transferred per context; must satisfy 1 <= NUM_REGS <= 2**ADDR_W.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
save_start  in  1  single-cycle request to begin a save.
restore_start  in  1  single-cycle request to begin a restore.
abort  in  1  cancel the current operation.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse when an operation completes normally.
rf_read_addr  out  ADDR_W  register file read address.
rf_read_data  in  DATA_W  register file read data, combinational from rf_read_addr.
rf_write_en  out  1  register file write enable.
rf_write_dest  out  ADDR_W  register file write address.
rf_write_data  out  DATA_W  register file write data.
out_valid  out  1  save stream word valid.
out_ready  in  1  save stream sink ready.
out_data  out  DATA_W  save stream word.
out_addr  out  ADDR_W  register index of out_data.
in_valid  in  1  restore stream word valid.
in_ready  out  1  engine ready for a restore word.
in_data  in  DATA_W  restore stream word.
ctx_csum  out  DATA_W  context checksum (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE, index 0.
  - All outputs 0: busy, done, rf_read_addr, rf_write_en, rf_write_dest, rf_write_data, out_valid, out_data, out_addr, in_ready, ctx_csum.
- States: IDLE, SAVE, RESTORE, FINISH.
- IDLE:
  - save_start → SAVE.
  - Else restore_start → RESTORE.
  - Both high in the same cycle: save wins.
  - Starts while not IDLE are ignored.
- SAVE:
  - rf_read_addr = index of the next word to load.
  - Cycle after entry: out_data=R[0], out_addr=0, out_valid=1 (registered).
  - out_data/out_addr are held stable while out_valid & !out_ready.
  - On handshake (out_valid & out_ready) at edge E with out_addr<NUM_REGS-1: load R[out_addr+1] at E. Back-to-back sustains 1 word/cycle.
  - Handshake on out_addr=NUM_REGS-1: out_valid drops at that edge, go to FINISH.
- RESTORE:
  - in_ready=1 from the cycle after entry until NUM_REGS words are accepted.
  - Handshake at edge E registers the write: during the following cycle rf_write_en=1, rf_write_dest=index, rf_write_data=in_data. The register file commits at E+1.
  - Index increments per handshake. After word NUM_REGS-1 is accepted, in_ready=0 at that edge and the state goes to FINISH.
  - rf_write_en is low in every cycle not preceded by a handshake.
- FINISH:
  - Waits until no write is pending, then asserts done=1 for exactly one cycle and returns to IDLE.
  - busy falls in the same cycle done is high.
  - Earliest new start is sampled in the cycle after done.
- abort (any non-IDLE state):
  - Next edge: IDLE, out_valid=0, in_ready=0, rf_write_en=0 (a pending registered write is cancelled), index=0, no done pulse.
  - abort in IDLE has no effect.
  - abort and start in the same cycle in IDLE: start is taken.
- Index wrap: index never exceeds NUM_REGS-1 and resets to 0 on every start.
- rf_read_addr is held at 0 outside SAVE.

Optional Feature:
- Macro GPR_CTX_CSUM_EN defined:
  - ctx_csum clears to 0 on each start.
  - It XOR-accumulates every handshaken word (out_data in save, in_data in restore).
  - Final value is valid from the done cycle until the next start.
- Macro undefined: ctx_csum is tied to 0 and no accumulator logic exists.

Test Plan:
- Preload R[i]=16'h1110+i, pulse save_start, out_ready=1 → 8 consecutive beats out_addr 0..7 with data 1110..1117, done one cycle after the last beat, busy low afterwards.
- Save with out_ready toggling 1,0,0,1 pattern → no word dropped or duplicated, out_data stable while stalled, same 8-word sequence.
- Restore with in_data=16'hA000+i, in_valid=1 → rf_write_en pulses 8 times, dests 0..7 with data A000..A007 one cycle after each handshake, done after the final write, register file readback matches.
- save_start and restore_start high together → save performed; restore_start pulsed mid-save → ignored.
- abort after the 3rd restore handshake → at most 3 writes commit (R0..R2), no done, busy=0 next cycle; rst_n low mid-save → all outputs 0 immediately.
- With GPR_CTX_CSUM_EN, save of the first scenario's data → ctx_csum=16'h0000 (XOR of 1110..1117); restore of A000..A007 → 16'h0000. Restore R[i]=16'h0001<<i → 16'h00FF.
